alu_serial_nb: RTL and testbench



---
 rtl/alu_serial_nb.sv | 163 ++++++++++++++++
 tb/tb_alu_serial_nb.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_nb.sv
// alu_serial_nb: digit-serial ADD/ADC/SUB/SBB unit.
// A SLICE-bit adder walks the WIDTH-bit operands LSB first over
// NSLICE = WIDTH/SLICE cycles. Result and C/Z/N/V are registered and only
// change on the edge that raises done, so downstream logic never sees a
// partial sum. The stored C flag can seed the next ADC/SBB for multi-word
// arithmetic.
module alu_serial_nb #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       sel,
   input  logic             cin,
   input  logic             use_flag_c,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             C,
   output logic             Z,
   output logic             N,
   output logic             V
);

   localparam int NSLICE = WIDTH / SLICE;
   // Keep the counter at least one bit wide so SLICE == WIDTH still elaborates.
   localparam int CNT_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

   // Operation encoding on sel.
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_ADC = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b10;
   localparam logic [1:0] OP_SBB = 2'b11;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_q;       // operand A, shifted right one slice per cycle
   logic [WIDTH-1:0] b_q;       // operand B' (already inverted for SUB/SBB)
   logic [WIDTH-1:0] part_q;    // partial sum, filled from the top
   logic             carry_q;   // carry between slices
   logic [CNT_W-1:0] cnt_q;     // index of the slice being added

   // Accept-time operand preparation.
   logic             ci;
   logic [WIDTH-1:0] b_prep;
   logic             k_prep;

   // Slice adder outputs.
   logic [SLICE:0]   slice_sum;
   logic             slice_cout;
   logic             msb_cin;
   logic [WIDTH-1:0] part_next;

   // Select the incoming carry, invert B for subtraction and choose k.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can
      // leave it unassigned and infer a latch.
      ci     = use_flag_c ? C : cin;
      b_prep = dataB;
      k_prep = 1'b0;
      case (sel)
         OP_ADD: begin
            b_prep = dataB;
            k_prep = 1'b0;
         end
         OP_ADC: begin
            b_prep = dataB;
            k_prep = ci;
         end
         OP_SUB: begin
            b_prep = ~dataB;
            k_prep = 1'b1;
         end
         OP_SBB: begin
            b_prep = ~dataB;
            k_prep = ~ci;
         end
         default: begin
            b_prep = dataB;
            k_prep = 1'b0;
         end
      endcase
   end

   // Add the current low slice and splice the sum onto the top of the partial.
   always_comb begin
      slice_sum  = {1'b0, a_q[SLICE-1:0]} + {1'b0, b_q[SLICE-1:0]}
                 + {{SLICE{1'b0}}, carry_q};
      slice_cout = slice_sum[SLICE];
      // The carry into the slice's top bit is recovered from sum = a ^ b ^ cin;
      // on the final slice this is the carry into bit WIDTH-1, for any SLICE.
      msb_cin    = a_q[SLICE-1] ^ b_q[SLICE-1] ^ slice_sum[SLICE-1];
      part_next  = WIDTH'({slice_sum[SLICE-1:0], part_q} >> SLICE);
   end

   // Control FSM with registered datapath, handshake and flag outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the operand and partial-sum registers are reset along with the
         // outputs so an aborted operation leaves no stale state behind.
         state   <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         part_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         C       <= 1'b0;
         Z       <= 1'b0;
         N       <= 1'b0;
         V       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register here
         // updates from pre-edge values regardless of statement order.
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_q     <= dataA;
                  b_q     <= b_prep;
                  carry_q <= k_prep;
                  part_q  <= '0;
                  cnt_q   <= '0;
                  busy    <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: begin
               a_q     <= a_q >> SLICE;
               b_q     <= b_q >> SLICE;
               carry_q <= slice_cout;
               part_q  <= part_next;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (cnt_q == LAST_CNT) begin
                  result <= part_next;
                  C      <= slice_cout;
                  Z      <= ~|part_next;
                  N      <= part_next[WIDTH-1];
                  V      <= msb_cin ^ slice_cout;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_serial_nb.sv
// Self-checking bench for alu_serial_nb. Four instances cover the default
// 16/4 configuration, SLICE=1, SLICE=WIDTH and WIDTH=32/SLICE=8. Inputs are
// shared; each instance has its own start so only one runs at a time.
module tb_alu_serial_nb;

   localparam logic [1:0] ADD = 2'b00;
   localparam logic [1:0] ADC = 2'b01;
   localparam logic [1:0] SUB = 2'b10;
   localparam logic [1:0] SBB = 2'b11;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  start_s;
   logic [1:0]  sel_in;
   logic        cin_in;
   logic        ufc_in;
   logic [31:0] a_in;
   logic [31:0] b_in;

   logic [3:0]  busy_s, done_s, c_s, z_s, n_s, v_s;
   logic [15:0] r0, r1, r2;
   logic [31:0] r3;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   alu_serial_nb #(.WIDTH(16), .SLICE(4)) u_d0 (
      .clk(clk), .rst_n(rst_n), .start(start_s[0]), .sel(sel_in), .cin(cin_in),
      .use_flag_c(ufc_in), .dataA(a_in[15:0]), .dataB(b_in[15:0]),
      .busy(busy_s[0]), .done(done_s[0]), .result(r0),
      .C(c_s[0]), .Z(z_s[0]), .N(n_s[0]), .V(v_s[0]));

   alu_serial_nb #(.WIDTH(16), .SLICE(1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .start(start_s[1]), .sel(sel_in), .cin(cin_in),
      .use_flag_c(ufc_in), .dataA(a_in[15:0]), .dataB(b_in[15:0]),
      .busy(busy_s[1]), .done(done_s[1]), .result(r1),
      .C(c_s[1]), .Z(z_s[1]), .N(n_s[1]), .V(v_s[1]));

   alu_serial_nb #(.WIDTH(16), .SLICE(16)) u_d2 (
      .clk(clk), .rst_n(rst_n), .start(start_s[2]), .sel(sel_in), .cin(cin_in),
      .use_flag_c(ufc_in), .dataA(a_in[15:0]), .dataB(b_in[15:0]),
      .busy(busy_s[2]), .done(done_s[2]), .result(r2),
      .C(c_s[2]), .Z(z_s[2]), .N(n_s[2]), .V(v_s[2]));

   alu_serial_nb #(.WIDTH(32), .SLICE(8)) u_d3 (
      .clk(clk), .rst_n(rst_n), .start(start_s[3]), .sel(sel_in), .cin(cin_in),
      .use_flag_c(ufc_in), .dataA(a_in), .dataB(b_in),
      .busy(busy_s[3]), .done(done_s[3]), .result(r3),
      .C(c_s[3]), .Z(z_s[3]), .N(n_s[3]), .V(v_s[3]));

   typedef struct {
      int          inst;
      logic [1:0]  sel;
      logic        cin;
      logic        ufc;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        c, z, n, v;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [31:0] res_of(int i);
      case (i)
         0:       return {16'h0, r0};
         1:       return {16'h0, r1};
         2:       return {16'h0, r2};
         default: return r3;
      endcase
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_out(string name, int i, logic [31:0] res,
                            logic c, logic z, logic n, logic v);
      check({name, " result"}, res_of(i), res);
      check({name, " flags CZNV"}, {28'h0, c_s[i], z_s[i], n_s[i], v_s[i]},
            {28'h0, c, z, n, v});
   endtask

   // Present an op and hold start for one edge; returns #1 after accept edge E0.
   task automatic issue(int i, logic [1:0] s, logic ci, logic u,
                        logic [31:0] a, logic [31:0] b);
      sel_in = s; cin_in = ci; ufc_in = u; a_in = a; b_in = b;
      start_s[i] = 1'b1;
      @(posedge clk); #1;
      start_s[i] = 1'b0;
   endtask

   // Count edges until done; returns #1 after the edge that raised done.
   task automatic wait_done(int i, output int lat, output int bcnt);
      lat = 0; bcnt = 0;
      while (done_s[i] !== 1'b1 && lat < 200) begin
         if (busy_s[i] === 1'b1) bcnt++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_vec(vec_t t, int idx);
      int    lat, bcnt;
      string nm;
      nm = $sformatf("vec%0d", idx);
      issue(t.inst, t.sel, t.cin, t.ufc, t.a, t.b);
      wait_done(t.inst, lat, bcnt);
      check({nm, " latency"}, lat, t.lat);
      check({nm, " busy cycles"}, bcnt, t.lat);
      check({nm, " busy low with done"}, {31'h0, busy_s[t.inst]}, 32'h0);
      check_out(nm, t.inst, t.res, t.c, t.z, t.n, t.v);
      @(posedge clk); #1;
      check({nm, " done one cycle"}, {31'h0, done_s[t.inst]}, 32'h0);
   endtask

   initial begin
      int lat, bcnt, ndone, nbusy;

      // inst, sel, cin, ufc, a, b, result, C, Z, N, V, latency
      vecs.push_back('{0, ADD, 1'b0, 1'b0, 32'h0003, 32'h0005, 32'h0008, 0, 0, 0, 0, 4});
      vecs.push_back('{0, SUB, 1'b0, 1'b0, 32'h1234, 32'h1234, 32'h0000, 1, 1, 0, 0, 4});
      vecs.push_back('{0, SBB, 1'b1, 1'b0, 32'h0005, 32'h0003, 32'h0001, 1, 0, 0, 0, 4});
      vecs.push_back('{0, ADD, 1'b0, 1'b0, 32'h7FFF, 32'h0001, 32'h8000, 0, 0, 1, 1, 4});
      vecs.push_back('{0, SUB, 1'b0, 1'b0, 32'h8000, 32'h0001, 32'h7FFF, 1, 0, 0, 1, 4});
      vecs.push_back('{1, ADD, 1'b0, 1'b0, 32'h0003, 32'h0005, 32'h0008, 0, 0, 0, 0, 16});
      vecs.push_back('{1, SBB, 1'b1, 1'b0, 32'h0005, 32'h0003, 32'h0001, 1, 0, 0, 0, 16});
      vecs.push_back('{1, ADD, 1'b0, 1'b0, 32'h7FFF, 32'h0001, 32'h8000, 0, 0, 1, 1, 16});
      vecs.push_back('{2, ADD, 1'b0, 1'b0, 32'h0003, 32'h0005, 32'h0008, 0, 0, 0, 0, 1});
      vecs.push_back('{2, SBB, 1'b1, 1'b0, 32'h0005, 32'h0003, 32'h0001, 1, 0, 0, 0, 1});
      vecs.push_back('{2, SUB, 1'b0, 1'b0, 32'h8000, 32'h0001, 32'h7FFF, 1, 0, 0, 1, 1});
      vecs.push_back('{3, ADD, 1'b0, 1'b0, 32'h0000_0003, 32'h0000_0005, 32'h0000_0008, 0, 0, 0, 0, 4});
      vecs.push_back('{3, SBB, 1'b1, 1'b0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0001, 1, 0, 0, 0, 4});
      vecs.push_back('{3, ADD, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 0, 1, 1, 4});

      rst_n = 1'b0; start_s = '0; sel_in = ADD; cin_in = 1'b0; ufc_in = 1'b0;
      a_in = '0; b_in = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("reset inst%0d busy/done", i),
               {30'h0, busy_s[i], done_s[i]}, 32'h0);
         check_out($sformatf("reset inst%0d", i), i, 32'h0, 0, 0, 0, 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int k = 0; k < vecs.size(); k++) run_vec(vecs[k], k);

      // Chain: ADD FFFF+0001 then back-to-back ADC taking the stored carry.
      issue(0, ADD, 1'b0, 1'b0, 32'hFFFF, 32'h0001);
      wait_done(0, lat, bcnt);
      check("chain add latency", lat, 4);
      check_out("chain add", 0, 32'h0000, 1, 1, 0, 0);
      issue(0, ADC, 1'b0, 1'b1, 32'h0001, 32'h0002);
      check("chain adc accepted in done cycle", {31'h0, busy_s[0]}, 32'h1);
      wait_done(0, lat, bcnt);
      check("chain adc latency", lat, 4);
      check_out("chain adc", 0, 32'h0004, 0, 0, 0, 0);

      // Start during busy cycle 2 with new operands must be ignored.
      @(posedge clk); #1;
      issue(0, ADD, 1'b0, 1'b0, 32'h0100, 32'h0200);
      @(posedge clk); #1;
      sel_in = SBB; a_in = 32'hFFFF; b_in = 32'hFFFF; cin_in = 1'b1;
      start_s[0] = 1'b1;
      @(posedge clk); #1;
      start_s[0] = 1'b0;
      wait_done(0, lat, bcnt);
      check("ignored start latency", lat + 2, 4);
      check_out("ignored start", 0, 32'h0300, 0, 0, 0, 0);
      ndone = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (done_s[0] === 1'b1) ndone++;
      end
      check("ignored start no second done", ndone, 0);

      // Reset during busy cycle 2 aborts immediately.
      issue(0, ADD, 1'b0, 1'b0, 32'h0003, 32'h0005);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("abort busy/done", {30'h0, busy_s[0], done_s[0]}, 32'h0);
      check_out("abort", 0, 32'h0000, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0; nbusy = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (done_s[0] === 1'b1) ndone++;
         if (busy_s[0] === 1'b1) nbusy++;
      end
      check("abort no done after release", ndone, 0);
      check("abort stays idle", nbusy, 0);

      // Block is usable again after the abort.
      run_vec('{0, ADD, 1'b0, 1'b0, 32'h0003, 32'h0005, 32'h0008, 0, 0, 0, 0, 4}, 99);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
